// File: rtl/systolic_stream_ctrl_if.sv
// Stream and core-side signal bundle for the systolic stream controller.
// master is the controller's view; slave is the upstream/core/downstream side.
interface systolic_stream_ctrl_if #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32
);
  logic                        act_valid;
  logic                        act_ready;
  logic [N*DATA_WIDTH-1:0]     act_data;
  logic                        act_last;
  logic [N-1:0]                core_valid_in;
  logic [N*DATA_WIDTH-1:0]     core_x_in;
  logic [N*ACC_WIDTH-1:0]      core_y_in;
  logic [N*ACC_WIDTH-1:0]      core_y_out;
  logic [N-1:0]                core_valid_out;
  logic                        res_valid;
  logic                        res_ready;
  logic [N*ACC_WIDTH-1:0]      res_data;
  logic                        res_last;

  modport master (
    input  act_valid, act_data, act_last, core_y_out, core_valid_out, res_ready,
    output act_ready, core_valid_in, core_x_in, core_y_in, res_valid, res_data, res_last
  );

  modport slave (
    output act_valid, act_data, act_last, core_y_out, core_valid_out, res_ready,
    input  act_ready, core_valid_in, core_x_in, core_y_in, res_valid, res_data, res_last
  );
endinterface

// File: rtl/systolic_stream_ctrl.sv
// Feeds activation rows into the aligned systolic core and buffers its results;
// issue is credit-gated so every in-flight row always has a result FIFO slot.
module systolic_stream_ctrl #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int OUT_DEPTH  = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  output logic done,
  output logic ovf_err,
  systolic_stream_ctrl_if.master bus
);
  localparam int CW = $clog2(OUT_DEPTH + 1);
  localparam int PW = $clog2(OUT_DEPTH);
  localparam int XW = N * DATA_WIDTH;
  localparam int YW = N * ACC_WIDTH;
  localparam logic [CW-1:0] FULL_C = CW'(OUT_DEPTH);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t          state, state_nxt;
  logic            act_rdy, act_hs, res_pop, res_full, res_push;
  logic            ret_all, ret_part, ret;
  logic [CW-1:0]   inflight, res_cnt;
  logic [CW:0]     credit_used;
  logic [PW-1:0]   tag_wp, tag_rp, res_wp, res_rp;
  logic            tag_mem [OUT_DEPTH];
  logic [YW:0]     res_mem [OUT_DEPTH];
  logic            tag_head;
  logic [YW:0]     res_head;
  logic            issue_vld;
  logic [XW-1:0]   issue_dat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = STREAM;
      STREAM:  if (act_hs && bus.act_last) state_nxt = DRAIN;
      DRAIN:   if (res_pop && res_head[YW]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A pop in the same cycle is not credited, keeping the check purely registered.
  always_comb begin
    busy    = (state != IDLE);
    act_rdy = (state == STREAM) && (credit_used < {1'b0, FULL_C});
  end

  assign credit_used = {1'b0, inflight} + {1'b0, res_cnt};
  assign act_hs      = bus.act_valid && act_rdy;
  assign bus.act_ready = act_rdy;

  assign ret_all  = &bus.core_valid_out;
  assign ret_part = (|bus.core_valid_out) && !ret_all;
  assign ret      = ret_all && (inflight != '0);

  assign tag_head = tag_mem[tag_rp];
  assign res_head = res_mem[res_rp];
  assign res_full = (res_cnt == FULL_C);
  assign res_pop  = bus.res_valid && bus.res_ready;
  assign res_push = ret && (!res_full || res_pop);

  assign bus.res_valid = (res_cnt != '0);
  assign bus.res_data  = bus.res_valid ? res_head[YW-1:0] : '0;
  assign bus.res_last  = bus.res_valid && res_head[YW];

  assign bus.core_valid_in = {N{issue_vld}};
  assign bus.core_x_in     = issue_dat;
  assign bus.core_y_in     = '0;

  always_ff @(posedge clk) begin
    if (act_hs)   tag_mem[tag_wp] <= bus.act_last;
    if (res_push) res_mem[res_wp] <= {tag_head, bus.core_y_out};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_wp    <= '0;
      tag_rp    <= '0;
      res_wp    <= '0;
      res_rp    <= '0;
      inflight  <= '0;
      res_cnt   <= '0;
      issue_vld <= 1'b0;
      issue_dat <= '0;
      ovf_err   <= 1'b0;
      done      <= 1'b0;
    end else begin
      issue_vld <= act_hs;
      issue_dat <= act_hs ? bus.act_data : '0;
      if (act_hs)   tag_wp <= tag_wp + 1'b1;
      if (ret)      tag_rp <= tag_rp + 1'b1;
      if (res_push) res_wp <= res_wp + 1'b1;
      if (res_pop)  res_rp <= res_rp + 1'b1;
      case ({act_hs, ret})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
      case ({res_push, res_pop})
        2'b10:   res_cnt <= res_cnt + 1'b1;
        2'b01:   res_cnt <= res_cnt - 1'b1;
        default: res_cnt <= res_cnt;
      endcase
      // A dropped row still consumes its tag so later results stay aligned.
      if (ret_part || (ret_all && inflight == '0) || (ret && res_full && !res_pop))
        ovf_err <= 1'b1;
      done <= (state == DRAIN) && res_pop && res_head[YW];
    end
  end
endmodule

// File: doc/systolic_stream_ctrl.md
Name: systolic_stream_ctrl

Overview:
- Producer/consumer end of the aligned systolic core interface.
- Accepts activation rows from an upstream valid/ready stream and issues them to the core as aligned rows with all-lane valid and zero partial sums.
- Captures the core's aligned result rows into an output FIFO and presents them downstream with valid/ready and last framing.
- Because the core has no backpressure, issue is gated by credits so every in-flight row is guaranteed a FIFO slot.

Parameters:
- N, 8, array dimension (lanes per row)
- DATA_WIDTH, 8, activation element width
- ACC_WIDTH, 32, result element width
- OUT_DEPTH, 16, result FIFO depth in rows; also the maximum number of in-flight rows (power of 2, ≥2)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin a tile; sampled only in IDLE
- busy  out  1  high when state ≠ IDLE
- done  out  1  one-cycle pulse after the final result row is accepted downstream
- ovf_err  out  1  sticky: core result arrived with the FIFO full, or valid lanes mismatched
- act_valid  in  1  upstream row valid
- act_ready  out  1  upstream row accept
- act_data  in  N*DATA_WIDTH  activation row, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
- act_last  in  1  marks the final row of the tile
- core_valid_in  out  N  to core valid_in
- core_x_in  out  N*DATA_WIDTH  to core x_in
- core_y_in  out  N*ACC_WIDTH  to core y_in; constant zero
- core_y_out  in  N*ACC_WIDTH  from core y_out (aligned)
- core_valid_out  in  N  from core valid_out (aligned)
- res_valid  out  1  downstream result valid
- res_ready  in  1  downstream accept
- res_data  out  N*ACC_WIDTH  result row
- res_last  out  1  result row corresponds to the row issued with act_last

Behaviour:
- Reset state: IDLE; all outputs 0; FIFOs empty; counters 0; ovf_err cleared only by reset.
- FSM IDLE→STREAM on start. STREAM→DRAIN on an act handshake with act_last=1. DRAIN→IDLE on a res handshake with res_last=1; done=1 in the following cycle. start outside IDLE is ignored.
- act_ready = (state==STREAM) && (inflight + fifo_count < OUT_DEPTH).
  - Same-cycle FIFO pop is not credited (conservative).
  - act_ready is forced 0 in the cycle after the last row is accepted.
- Issue:
  - Handshake at cycle t → during t+1, core_valid_in = all ones and core_x_in = act_data captured at t.
  - Otherwise core_valid_in = 0 and core_x_in = 0. No combinational path from act_data to core_x_in.
- Tag FIFO (depth OUT_DEPTH, 1 bit): each issue pushes act_last; each core return pops. Matching is by order, so no core-latency parameter is needed.
- inflight counter (clog2(OUT_DEPTH+1) bits):
  - +1 on issue, -1 on core return; unchanged when both occur in the same cycle.
  - A core return with inflight==0 sets ovf_err and is ignored.
- Core return is detected when core_valid_out == all ones. If core_valid_out is neither all 0 nor all 1, set ovf_err and treat it as no return.
- Result FIFO (OUT_DEPTH × (N*ACC_WIDTH+1)):
  - On a return, push {tag, core_y_out}.
  - If full at that moment (should be impossible by credits), set ovf_err and drop the row; still pop the tag and decrement inflight.
  - Simultaneous push and pop is allowed when full or empty; count is unchanged.
- Downstream: res_valid = FIFO not empty; res_data/res_last come from the FIFO head (registered or first-word-fall-through). Data is held stable while res_valid && !res_ready.
- busy = (state≠IDLE). done is high for exactly 1 cycle per tile.
- Async reset mid-tile returns everything to reset state immediately. In-flight core results arriving after reset (the core is also reset) are not expected; if they arrive in IDLE they are still counted as errors (inflight==0 → ovf_err).

Test Plan:
1. N=8, OUT_DEPTH=4, res_ready=1. start, then 3 rows (lane values 1..8, 9..16, 17..24), last on row 3; core model = 2N-cycle delay, y = x sign-extended. Expect 3 res rows in order, res_last only on the third, done 1 cycle after it, busy 0 afterwards.
2. Backpressure: res_ready=0, feed 10 rows. Expect act_ready to fall after 4 accepted rows and never exceed 4 inflight+stored. Then release res_ready: all 10 rows arrive in order and ovf_err stays 0.
3. Single-row tile (act_last on first row): core_valid_in high exactly 1 cycle, one res row with res_last=1, done pulse.
4. start asserted in STREAM: no effect. act_valid held high in IDLE: act_ready stays 0.
5. Inject a core_valid_out=8'h0F pulse: ovf_err=1 and sticky, nothing pushed. Inject a core return with inflight 0: ovf_err stays 1, nothing pushed.
6. Assert rst_n low with 2 rows stored and 2 in flight: all outputs 0 asynchronously. After release: IDLE, res_valid 0, and a new tile completes normally.
